// File: rtl/number_guesser.sv
// number_guesser: plays one game of number baseball, always proposing the lowest
// 4-digit BCD guess consistent with every scored reply received so far.
module number_guesser #(
    parameter int HIST_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [15:0] question,
    output logic        ask_valid,
    input  logic        reply_ready,
    input  logic        reply_valid,
    input  logic [2:0]  strike,
    input  logic [2:0]  ball,
    input  logic        correct,
    output logic        ask_ready,
    output logic        busy,
    output logic        done,
    output logic        solved,
    output logic [15:0] solution,
    output logic [7:0]  tries
);
    localparam int CW = $clog2(HIST_DEPTH + 1);
    localparam int AW = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;
    localparam logic [CW-1:0] FULL = CW'(HIST_DEPTH);
    localparam logic [15:0] FIRST = 16'h0123;
    localparam logic [15:0] LAST = 16'h9876;

    typedef enum logic [2:0] {IDLE, CHECK, NEXT, ASK, WAIT, CAPT, DONE} state_t;

    state_t        state, state_d;
    logic [15:0]   cand, cand_d, question_d, solution_d, inc;
    logic [CW-1:0] idx, idx_d, hist_cnt, hist_cnt_d;
    logic [7:0]    tries_d;
    logic          ask_valid_d, ask_ready_d, busy_d, done_d, solved_d;
    logic [2:0]    cap_strike, cap_strike_d, cap_ball, cap_ball_d, cs, cb;
    logic          cap_correct, cap_correct_d, hist_we;
    logic [15:0]   hist_q [HIST_DEPTH];
    logic [2:0]    hist_s [HIST_DEPTH];
    logic [2:0]    hist_b [HIST_DEPTH];

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                c = r[4*i +: 4] == 4'd9;
                r[4*i +: 4] = c ? 4'd0 : r[4*i +: 4] + 4'd1;
            end
        end
        return r;
    endfunction

    function automatic logic repeats(input logic [15:0] v);
        logic r;
        r = 1'b0;
        for (int i = 0; i < 4; i++)
            for (int j = i + 1; j < 4; j++)
                r |= v[4*i +: 4] == v[4*j +: 4];
        return r;
    endfunction

    // {strike, ball} of candidate c as seen from history question q
    function automatic logic [5:0] score(input logic [15:0] q, input logic [15:0] c);
        logic [2:0] s, b;
        logic       hit;
        s = '0;
        b = '0;
        for (int i = 0; i < 4; i++) begin
            hit = 1'b0;
            for (int j = 0; j < 4; j++)
                hit |= (j != i) && (q[4*i +: 4] == c[4*j +: 4]);
            if (q[4*i +: 4] == c[4*i +: 4])
                s = s + 3'd1;
            else if (hit)
                b = b + 3'd1;
        end
        return {s, b};
    endfunction

    assign {cs, cb} = score(hist_q[idx[AW-1:0]], cand);
    assign inc = bcd_inc(cand);

    always_comb begin
        state_d       = state;
        cand_d        = cand;
        idx_d         = idx;
        hist_cnt_d    = hist_cnt;
        question_d    = question;
        solution_d    = solution;
        tries_d       = tries;
        ask_valid_d   = ask_valid;
        ask_ready_d   = ask_ready;
        done_d        = done;
        solved_d      = solved;
        cap_strike_d  = cap_strike;
        cap_ball_d    = cap_ball;
        cap_correct_d = cap_correct;
        hist_we       = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_d    = CHECK;
                    cand_d     = FIRST;
                    hist_cnt_d = '0;
                    tries_d    = '0;
                    done_d     = 1'b0;
                    solved_d   = 1'b0;
                    idx_d      = '0;
                end
            end
            CHECK: begin
                if (idx == hist_cnt) begin
                    state_d     = ASK;
                    question_d  = cand;
                    ask_valid_d = 1'b1;
                end else if ({cs, cb} != {hist_s[idx[AW-1:0]], hist_b[idx[AW-1:0]]}) begin
                    state_d = NEXT;
                end else begin
                    idx_d = idx + 1'b1;
                end
            end
            NEXT: begin
                if (cand == LAST) begin
                    state_d  = DONE;
                    done_d   = 1'b1;
                    solved_d = 1'b0;
                end else begin
                    cand_d = inc;
                    if (!repeats(inc)) begin
                        idx_d   = '0;
                        state_d = CHECK;
                    end
                end
            end
            ASK: begin
                if (reply_ready) begin
                    ask_valid_d = 1'b0;
                    tries_d     = tries + 8'd1;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                if (reply_valid) begin
                    cap_strike_d  = strike;
                    cap_ball_d    = ball;
                    cap_correct_d = correct;
                    ask_ready_d   = 1'b1;
                    state_d       = CAPT;
                end
            end
            CAPT: begin
                ask_ready_d = 1'b0;
                if (cap_correct) begin
                    solution_d = question;
                    solved_d   = 1'b1;
                    done_d     = 1'b1;
                    state_d    = DONE;
                end else begin
                    hist_we    = 1'b1;
                    hist_cnt_d = hist_cnt + 1'b1;
                    state_d    = (hist_cnt_d == FULL) ? DONE : NEXT;
                    done_d     = hist_cnt_d == FULL;
                    solved_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE) && (state_d != DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cand        <= '0;
            idx         <= '0;
            hist_cnt    <= '0;
            question    <= '0;
            solution    <= '0;
            tries       <= '0;
            ask_valid   <= 1'b0;
            ask_ready   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            solved      <= 1'b0;
            cap_strike  <= '0;
            cap_ball    <= '0;
            cap_correct <= 1'b0;
        end else begin
            state       <= state_d;
            cand        <= cand_d;
            idx         <= idx_d;
            hist_cnt    <= hist_cnt_d;
            question    <= question_d;
            solution    <= solution_d;
            tries       <= tries_d;
            ask_valid   <= ask_valid_d;
            ask_ready   <= ask_ready_d;
            busy        <= busy_d;
            done        <= done_d;
            solved      <= solved_d;
            cap_strike  <= cap_strike_d;
            cap_ball    <= cap_ball_d;
            cap_correct <= cap_correct_d;
        end
    end

    // history contents need no reset: hist_cnt alone marks which entries are live
    always_ff @(posedge clk) begin
        if (hist_we) begin
            hist_q[hist_cnt[AW-1:0]] <= question;
            hist_s[hist_cnt[AW-1:0]] <= cap_strike;
            hist_b[hist_cnt[AW-1:0]] <= cap_ball;
        end
    end
endmodule

// File: tb/tb_number_guesser.sv
// tb_number_guesser: grader model drives the guesser; a monitor scores each
// transferred question and each game result against queued expectations.
module tb_number_guesser;
    logic        clk = 1'b0, reset = 1'b0, start = 1'b0;
    logic [15:0] question, solution;
    logic        ask_valid, ask_ready, busy, done, solved;
    logic        reply_ready = 1'b0, reply_valid = 1'b0, correct = 1'b0;
    logic [2:0]  strike = '0, ball = '0;
    logic [7:0]  tries;

    logic        d2_start = 1'b0;
    logic [15:0] d2_question, d2_solution;
    logic        d2_ask_valid, d2_ask_ready, d2_busy, d2_done, d2_solved;
    logic        d2_reply_ready = 1'b0, d2_reply_valid = 1'b0, d2_correct = 1'b0;
    logic [2:0]  d2_strike = '0, d2_ball = '0;
    logic [7:0]  d2_tries;

    int n_checks = 0, n_fail = 0;
    int mode = 0, dly_max = 0;
    logic [15:0] answer = 16'h0123;

    typedef struct packed {
        logic        solved;
        logic [15:0] solution;
        logic [7:0]  tries;
        logic        tries_max;
    } res_t;

    logic [15:0] exp_q[$];
    res_t        res_q[$];

    number_guesser dut (
        .clk(clk), .reset(reset), .start(start), .question(question), .ask_valid(ask_valid),
        .reply_ready(reply_ready), .reply_valid(reply_valid), .strike(strike), .ball(ball),
        .correct(correct), .ask_ready(ask_ready), .busy(busy), .done(done), .solved(solved),
        .solution(solution), .tries(tries)
    );

    number_guesser #(.HIST_DEPTH(2)) dut2 (
        .clk(clk), .reset(reset), .start(d2_start), .question(d2_question), .ask_valid(d2_ask_valid),
        .reply_ready(d2_reply_ready), .reply_valid(d2_reply_valid), .strike(d2_strike), .ball(d2_ball),
        .correct(d2_correct), .ask_ready(d2_ask_ready), .busy(d2_busy), .done(d2_done), .solved(d2_solved),
        .solution(d2_solution), .tries(d2_tries)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // grader's score of guess g against the secret a: {strike, ball, correct}
    function automatic logic [6:0] grade(input logic [15:0] g, input logic [15:0] a);
        logic [2:0] s, b;
        s = '0;
        b = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                if (g[4*i +: 4] == a[4*j +: 4]) begin
                    if (i == j) s = s + 3'd1;
                    else b = b + 3'd1;
                end
        return {s, b, s == 3'd4};
    endfunction

    // mode 1 honest, 2 always 0S0B, 3 accept the question but never reply
    always begin : grader
        logic [15:0] g;
        @(negedge clk);
        if (mode != 0 && ask_valid && reset) begin
            repeat ($urandom_range(dly_max, 0)) @(negedge clk);
            reply_ready = 1'b1;
            g = question;
            @(negedge clk);
            reply_ready = 1'b0;
            if (mode != 3) begin
                repeat ($urandom_range(dly_max, 0)) @(negedge clk);
                {strike, ball, correct} = (mode == 2) ? 7'd0 : grade(g, answer);
                reply_valid = 1'b1;
                for (int i = 0; i < 20 && !ask_ready; i++) @(negedge clk);
                check("ask_ready_seen", ask_ready, 1);
                reply_valid = 1'b0;
                @(negedge clk);
                check("ask_ready_one_cycle", ask_ready, 0);
            end
        end
    end

    always begin : grader2
        logic [15:0] g;
        @(negedge clk);
        if (d2_ask_valid && reset) begin
            d2_reply_ready = 1'b1;
            g = d2_question;
            @(negedge clk);
            d2_reply_ready = 1'b0;
            {d2_strike, d2_ball, d2_correct} = grade(g, 16'h9876);
            d2_reply_valid = 1'b1;
            for (int i = 0; i < 20 && !d2_ask_ready; i++) @(negedge clk);
            d2_reply_valid = 1'b0;
        end
    end

    logic [15:0] held = '0;
    logic        unstable = 1'b0, prev_valid = 1'b0, prev_done = 1'b0;
    res_t        r;

    always @(negedge clk) begin
        if (ask_valid && !prev_valid) begin
            held = question;
            unstable = 1'b0;
        end else if (ask_valid && question != held) begin
            unstable = 1'b1;
        end
        if (ask_ready) check("ready_excl_valid", ask_valid, 0);
        if (prev_valid && !ask_valid && reset) begin
            check("question_stable", unstable, 0);
            check("busy_in_game", busy, 1);
            if (exp_q.size() != 0) check("question", held, exp_q.pop_front());
        end
        if (done && !prev_done) begin
            check("result_expected", res_q.size() != 0, 1);
            if (res_q.size() != 0) begin
                r = res_q.pop_front();
                check("solved", solved, r.solved);
                if (r.solved) check("solution", solution, r.solution);
                if (r.tries_max) check("tries_bound", tries <= r.tries, 1);
                else check("tries", tries, r.tries);
                check("busy_when_done", busy, 0);
                check("questions_left", exp_q.size(), 0);
            end
        end
        prev_valid = ask_valid;
        prev_done = done;
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, input string name);
        for (int i = 0; i < limit && !done; i++) @(negedge clk);
        check({name, "_done"}, done, 1);
        @(negedge clk);
    endtask

    initial begin
        #1500000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_ask_valid", ask_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_tries", tries, 0);
        reset = 1'b1;
        @(negedge clk);

        // immediate solve, with start-to-ask latency
        answer = 16'h0123; mode = 1; dly_max = 0;
        exp_q.push_back(16'h0123);
        res_q.push_back('{1'b1, 16'h0123, 8'd1, 1'b0});
        start = 1'b1; d2_start = 1'b1;
        @(negedge clk);
        start = 1'b0; d2_start = 1'b0;
        check("busy_after_start", busy, 1);
        check("ask_latency_1", ask_valid, 0);
        @(negedge clk);
        check("ask_latency_2", ask_valid, 1);
        wait_done(100, "t_0123");

        // depth-2 instance: history fills before the answer is reached
        for (int i = 0; i < 12000 && !d2_done; i++) @(negedge clk);
        check("d2_done", d2_done, 1);
        check("d2_solved", d2_solved, 0);
        check("d2_tries", d2_tries, 2);
        check("d2_last_question", d2_question, 16'h4567);

        // two guesses
        answer = 16'h4567; dly_max = 2;
        exp_q.push_back(16'h0123); exp_q.push_back(16'h4567);
        res_q.push_back('{1'b1, 16'h4567, 8'd2, 1'b0});
        pulse_start();
        wait_done(20000, "t_4567");

        // start while busy is ignored
        dly_max = 3;
        exp_q.push_back(16'h0123); exp_q.push_back(16'h4567);
        res_q.push_back('{1'b1, 16'h4567, 8'd2, 1'b0});
        pulse_start();
        for (int i = 0; i < 50 && !ask_valid; i++) @(negedge clk);
        pulse_start();
        wait_done(20000, "t_busy_start");

        // reset while waiting for the reply
        mode = 3; dly_max = 0;
        exp_q.push_back(16'h0123);
        pulse_start();
        for (int i = 0; i < 50 && !ask_valid; i++) @(negedge clk);
        for (int i = 0; i < 50 && ask_valid; i++) @(negedge clk);
        check("wait_busy", busy, 1);
        check("wait_tries", tries, 1);
        #2 reset = 1'b0;
        #1;
        check("arst_question", question, 0);
        check("arst_solution", solution, 0);
        check("arst_tries", tries, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_solved", solved, 0);
        check("arst_ask_valid", ask_valid, 0);
        check("arst_ask_ready", ask_ready, 0);
        check("arst_d2_done", d2_done, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        mode = 1; answer = 16'h0123;
        exp_q.push_back(16'h0123);
        res_q.push_back('{1'b1, 16'h0123, 8'd1, 1'b0});
        pulse_start();
        wait_done(100, "t_after_reset");

        // grader that never scores anything: candidates run out
        mode = 2;
        exp_q.push_back(16'h0123); exp_q.push_back(16'h4567);
        res_q.push_back('{1'b0, 16'h0000, 8'd2, 1'b0});
        pulse_start();
        wait_done(30000, "t_exhaust");

        // full game to the last candidate, random handshake delays
        mode = 1; answer = 16'h9876; dly_max = 5;
        exp_q.push_back(16'h0123); exp_q.push_back(16'h4567);
        res_q.push_back('{1'b1, 16'h9876, 8'd16, 1'b1});
        pulse_start();
        wait_done(60000, "t_9876");

        mode = 0;
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/number_guesser.md
# number_guesser

Upstream stage of the grader: autonomously plays one game of number baseball by proposing 4-digit guesses (distinct BCD digits 0–9, one per nibble, most significant digit in [15:12]) over the ask/reply handshake. It consumes the grader's strike/ball/correct reply and keeps a history of every guess and its score. Each next guess is the lowest-valued candidate consistent with the whole history. It reports the solution, or failure, when done.

## Interface
- HIST_DEPTH, 16: history entries; also the maximum number of guesses per game.

- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin a game; sampled only in IDLE or DONE.
- question  out  16  current guess; stable while ask_valid=1.
- ask_valid  out  1  guess offered to the grader.
- reply_ready  in  1  grader accepts guess; transfer = ask_valid & reply_ready.
- reply_valid  in  1  grader score available.
- strike  in  3  grader strike count (0–4).
- ball  in  3  grader ball count (0–4).
- correct  in  1  grader says all four digits are strikes.
- ask_ready  out  1  one-cycle acknowledge of the reply; consume = reply_valid & ask_ready.
- busy  out  1  game in progress (state not IDLE or DONE).
- done  out  1  game finished; held until the next start.
- solved  out  1  valid with done: 1 = solution found, 0 = failed.
- solution  out  16  last guess that received correct=1; valid when done & solved.
- tries  out  8  number of guesses transferred this game.

## Operation
- All outputs are registered. Reset values:
  - question=16'h0000, solution=16'h0000, tries=0.
  - ask_valid, ask_ready, busy, done, solved = 0.
  - FSM=IDLE, hist_cnt=0.
- Score of a candidate against a history question. For each question position i:
  - strike if the question digit equals the candidate digit at i;
  - else ball if it equals any other candidate digit.
  - Counts are summed over the four positions.
  - A candidate is consistent if, for every stored entry, its strike and ball counts equal the stored strike and ball.
- Candidate order: BCD increment of a 4-digit decimal counter, skipping any value with repeated digits.
  - First candidate is 16'h0123; last is 16'h9876.
- FSM states:
  - IDLE: on start, set cand=16'h0123, hist_cnt=0, tries=0, done=0, solved=0, idx=0, then go to CHECK.
  - CHECK: one history entry per cycle.
    - idx==hist_cnt → ASK; question<=cand, ask_valid<=1.
    - Score of cand vs entry idx mismatches the stored score → NEXT.
    - Otherwise idx<=idx+1.
  - NEXT: one BCD increment per cycle.
    - cand==16'h9876 → DONE with solved=0.
    - Else cand<=bcd_inc(cand); stay in NEXT if the result has repeated digits, otherwise idx=0 and go to CHECK.
  - ASK: hold ask_valid and question until ask_valid & reply_ready. On that edge, ask_valid<=0, tries<=tries+1, go to WAIT.
  - WAIT: on reply_valid, capture strike, ball and correct; set ask_ready<=1 for exactly one cycle; go to CAPT.
  - CAPT: ask_ready<=0, then resolve the captured reply:
    - correct captured → solution<=question, solved<=1, DONE.
    - Else write {question, strike, ball} to entry hist_cnt and hist_cnt<=hist_cnt+1.
    - If the new hist_cnt==HIST_DEPTH → DONE with solved=0.
    - Otherwise go to NEXT.
  - DONE: done=1, busy=0. start restarts exactly as from IDLE.
- start outside IDLE/DONE is ignored.
- ask_valid and ask_ready are never high in the same cycle.
- strike/ball values above 4 are stored as received (no saturation).

## Timing
- Game start: start sampled in IDLE → CHECK next cycle. With an empty history, ask_valid rises one cycle later (2 cycles after start).
- Consistency check: up to hist_cnt cycles per candidate; exits early on the first mismatch.
- Candidate increment: 1 cycle per skipped or rejected value.
- Handshake: the transfer completes on the first edge where ask_valid & reply_ready. Arbitrary reply_ready delay is tolerated, with question held stable.
- Reply: ask_ready is high the cycle after reply_valid is first sampled, so the grader drops reply_valid on that edge. The reply is captured on the edge where reply_valid is first sampled high.
- done asserts the cycle after CAPT or NEXT resolves the game.
- Asynchronous reset mid-game (any state) returns immediately to reset values and drops ask_valid/ask_ready. The history is invalidated via hist_cnt=0.

## Test plan
- Answer 16'h0123, start → ask 16'h0123; reply 4S0B correct → done=1, solved=1, solution=16'h0123, tries=1.
- Answer 16'h4567 → asks 0123 (score 0S0B), then 4567 → solved, tries=2.
- Answer 16'h9876, HIST_DEPTH=2 → 0123 scores 0S0B, 4567 scores 0S2B, history full → done=1, solved=0, tries=2.
- Answer 16'h9876, default depth, with random 0–5 cycle reply delays → solved=1, solution=16'h9876, tries≤16. question stable throughout each ask_valid; exactly one ask_ready per reply.
- Reset asserted in WAIT, then start → all outputs at reset values; new game's first ask is 16'h0123 and tries counts from 0.
- start pulsed while busy → ignored; tries and question unaffected.
